// File: rtl/pipe_stage_buf.sv
// Pipeline-stage register carrying a control and a data bundle under valid/ready.
// SKID=1 adds a second entry so in_ready can be registered; flush turns held beats into bubbles.
module pipe_stage_buf #(
    parameter int                CTRL_W      = 12,
    parameter int                DATA_W      = 134,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = {CTRL_W{1'b0}},
    parameter bit                SKID        = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    state_t            state_q, state_d;
    logic              rdy_q;
    logic              in_fire, out_fire;
    logic              ld_main_in, ld_main_skid, ld_skid;
    logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
    logic [DATA_W-1:0] main_data_q, skid_data_q;

    // rdy_q is low during reset; with SKID=0 it only gates the combinational ready
    assign in_ready  = SKID ? rdy_q : (rdy_q & (!out_valid | out_ready));
    assign out_valid = (state_q != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign out_ctrl  = out_valid ? main_ctrl_q : CTRL_BUBBLE;
    assign out_data  = main_data_q;
    assign occupancy = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d != TWO);
        end
    end

    always_comb begin
        state_d      = state_q;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        if (flush) begin
            // an out_fire this cycle has already been sampled downstream; everything else is dropped
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (in_fire) begin
                    state_d    = ONE;
                    ld_main_in = 1'b1;
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        ld_main_in = 1'b1;
                    end else if (in_fire && SKID) begin
                        state_d = TWO;
                        ld_skid = 1'b1;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                TWO: if (out_fire) begin
                    state_d      = ONE;
                    ld_main_skid = 1'b1;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_ctrl_q <= CTRL_BUBBLE;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else begin
            if (ld_main_in) begin
                main_ctrl_q <= in_ctrl;
                main_data_q <= in_data;
            end else if (ld_main_skid) begin
                main_ctrl_q <= skid_ctrl_q;
                main_data_q <= skid_data_q;
            end
            if (ld_skid) begin
                skid_ctrl_q <= in_ctrl;
                skid_data_q <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: SKID=1 and SKID=0 instances, per-instance scoreboards,
// a vector table for backpressure/flush and hand sequences for reset, bubble and replacement.
module tb_pipe_stage_buf;
    localparam int CW = 12;
    localparam int DW = 134;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // SKID=1 instance
    logic          fl, iv, ir, ov, ordy;
    logic [CW-1:0] ic, oc;
    logic [DW-1:0] id, od;
    logic [1:0]    occ;
    // SKID=0 instance
    logic          fl0, iv0, ir0, ov0, ordy0;
    logic [CW-1:0] ic0, oc0;
    logic [DW-1:0] id0, od0;
    logic [1:0]    occ0;

    pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(fl), .in_valid(iv), .in_ready(ir),
        .in_ctrl(ic), .in_data(id), .out_valid(ov), .out_ready(ordy),
        .out_ctrl(oc), .out_data(od), .occupancy(occ));

    pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(fl0), .in_valid(iv0), .in_ready(ir0),
        .in_ctrl(ic0), .in_data(id0), .out_valid(ov0), .out_ready(ordy0),
        .out_ctrl(oc0), .out_data(od0), .occupancy(occ0));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboards: push on accept, pop on deliver, sampled at negedge ahead of the firing edge
    logic [CW+DW-1:0] sb[$];
    logic [CW+DW-1:0] sb0[$];

    always @(negedge clk) if (rst_n) begin
        if (ov && ordy) begin
            if (sb.size() == 0) chk("sb1_underflow", 1, 0);
            else chk("sb1_beat", {oc, od}, sb.pop_front());
        end
        if (fl) sb.delete();
        else if (iv && ir) sb.push_back({ic, id});
    end

    always @(negedge clk) if (rst_n) begin
        if (ov0 && ordy0) begin
            if (sb0.size() == 0) chk("sb0_underflow", 1, 0);
            else chk("sb0_beat", {oc0, od0}, sb0.pop_front());
        end
        if (fl0) sb0.delete();
        else if (iv0 && ir0) sb0.push_back({ic0, id0});
    end

    always @(negedge rst_n) begin
        sb.delete();
        sb0.delete();
    end

    typedef struct packed {
        logic          iv;
        logic [CW-1:0] ic;
        logic [DW-1:0] id;
        logic          ordy;
        logic          fl;
        logic          ov;
        logic          ir;
        logic [1:0]    occ;
    } vec_t;

    vec_t tbl[15];

    task automatic set_row(input int k, input logic v, input int n, input logic r, input logic f,
                           input logic eov, input logic eir, input logic [1:0] eocc);
        tbl[k].iv   = v;
        tbl[k].ic   = CW'(12'h0A0 | n);
        tbl[k].id   = DW'(n);
        tbl[k].ordy = r;
        tbl[k].fl   = f;
        tbl[k].ov   = eov;
        tbl[k].ir   = eir;
        tbl[k].occ  = eocc;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // backpressure: A=1 B=2 C=3; flush in TWO: D=4 E=5 F=6; flush in ONE: G=7 H=8
        set_row(0,  1, 1, 1, 0, 0, 1, 0);
        set_row(1,  1, 2, 0, 0, 1, 1, 1);
        set_row(2,  1, 3, 0, 0, 1, 0, 2);
        set_row(3,  1, 3, 0, 0, 1, 0, 2);
        set_row(4,  1, 3, 1, 0, 1, 0, 2);
        set_row(5,  1, 3, 1, 0, 1, 1, 1);
        set_row(6,  0, 0, 1, 0, 1, 1, 1);
        set_row(7,  0, 0, 1, 0, 0, 1, 0);
        set_row(8,  1, 4, 0, 0, 0, 1, 0);
        set_row(9,  1, 5, 0, 0, 1, 1, 1);
        set_row(10, 1, 6, 1, 1, 1, 0, 2);
        set_row(11, 0, 0, 1, 0, 0, 1, 0);
        set_row(12, 1, 7, 0, 0, 0, 1, 0);
        set_row(13, 1, 8, 1, 1, 1, 1, 1);
        set_row(14, 0, 0, 1, 0, 0, 1, 0);

        rst_n = 1'b0;
        {fl, iv, ordy, fl0, iv0, ordy0} = '0;
        ic = '0; id = '0; ic0 = '0; id0 = '0;
        #3;
        chk("rst_out_valid", ov, 0);
        chk("rst_out_ctrl", oc, 0);
        chk("rst_out_data", od, 0);
        chk("rst_occ", occ, 0);
        chk("rst_in_ready", ir, 0);
        chk("rst_in_ready0", ir0, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        #1 chk("rel_in_ready_before_edge", ir, 0);
        cyc();
        chk("rel_in_ready", ir, 1);
        chk("rel_in_ready0", ir0, 1);

        // streaming, 8 beats back to back
        for (int i = 0; i < 8; i++) begin
            iv = 1'b1; ic = CW'(i); id = DW'(i); ordy = 1'b1;
            @(negedge clk);
            chk("stream_in_ready", ir, 1);
            chk("stream_out_valid", ov, (i != 0));
            if (i != 0) chk("stream_out_data", od, DW'(i - 1));
            cyc();
        end
        iv = 1'b0;
        @(negedge clk);
        chk("stream_last_valid", ov, 1);
        chk("stream_last_data", od, 7);
        cyc();
        @(negedge clk);
        chk("stream_drained", ov, 0);
        cyc();

        // backpressure and flush vectors
        for (int k = 0; k < 15; k++) begin
            iv = tbl[k].iv; ic = tbl[k].ic; id = tbl[k].id;
            ordy = tbl[k].ordy; fl = tbl[k].fl;
            @(negedge clk);
            chk($sformatf("tbl%0d_out_valid", k), ov, tbl[k].ov);
            chk($sformatf("tbl%0d_in_ready", k), ir, tbl[k].ir);
            chk($sformatf("tbl%0d_occ", k), occ, tbl[k].occ);
            if (!tbl[k].ov) chk($sformatf("tbl%0d_bubble", k), oc, 0);
            cyc();
        end
        fl = 1'b0; iv = 1'b0;
        chk("flush_keeps_data", od, 7);

        // bubble control: all-ones ctrl consumed, data held
        iv = 1'b1; ic = 12'hFFF; id = DW'(134'h3C3C_5A5A); ordy = 1'b1;
        cyc();
        iv = 1'b0; ic = '0; id = '0;
        @(negedge clk);
        chk("bubble_ctrl_live", oc, 12'hFFF);
        cyc();
        @(negedge clk);
        chk("bubble_ctrl", oc, 0);
        chk("bubble_data_held", od, 134'h3C3C_5A5A);
        cyc();

        // reset while two beats are held
        iv = 1'b1; ic = 12'h011; id = 11; ordy = 1'b0;
        cyc();
        ic = 12'h012; id = 12;
        cyc();
        iv = 1'b0;
        @(negedge clk);
        chk("pre_rst_occ", occ, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", ov, 0);
        chk("midrst_out_ctrl", oc, 0);
        chk("midrst_occ", occ, 0);
        chk("midrst_in_ready", ir, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        cyc();
        chk("midrst_rel_in_ready", ir, 1);
        ordy = 1'b1;

        // SKID=0: combinational ready and same-cycle replacement
        iv0 = 1'b1; ic0 = 12'h021; id0 = 21; ordy0 = 1'b1;
        #1 chk("s0_ready_empty", ir0, 1);
        cyc();
        ic0 = 12'h022; id0 = 22; ordy0 = 1'b0;
        #1 chk("s0_ready_blocked", ir0, 0);
        chk("s0_occ_one", occ0, 1);
        ordy0 = 1'b1;
        #1 chk("s0_ready_pass", ir0, 1);
        cyc();
        iv0 = 1'b0;
        @(negedge clk);
        chk("s0_no_bubble_valid", ov0, 1);
        chk("s0_replaced_data", od0, 22);
        chk("s0_occ", occ0, 1);
        cyc();
        @(negedge clk);
        chk("s0_drained", ov0, 0);
        cyc();

        chk("sb1_empty", sb.size(), 0);
        chk("sb0_empty", sb0.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline-stage register for the CPU datapath, the generalised successor to the fixed ID/EX latch. It carries one control bundle and one data bundle per beat under a valid/ready handshake. It can optionally use a 2-entry skid buffer to break the backpressure path, and it supports a synchronous flush that turns held beats into bubbles. One instance sits between each pair of pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface
- CTRL_W, 12, control bundle width (ID/EX: regwrt, branch, btype, jump, memtoreg, memrd, memwrt, aluop[2:0], alusrc1, alusrc0)
- DATA_W, 134, data bundle width (ID/EX: pc, rs, rt, x, rd[5:0])
- CTRL_BUBBLE, {CTRL_W{1'b0}}, control value presented whenever out_valid=0
- SKID, 1, 1 = 2-entry skid with registered in_ready; 0 = single entry with combinational in_ready

- clk  in  1  clock; all state updates on rising edge only (no negedge logic)
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous kill of all held beats and of any same-cycle input beat
- in_valid  in  1  upstream beat valid
- in_ready  out  1  stage accepts a beat this cycle
- in_ctrl  in  CTRL_W  upstream control bundle
- in_data  in  DATA_W  upstream data bundle
- out_valid  out  1  beat available downstream
- out_ready  in  1  downstream accepts
- out_ctrl  out  CTRL_W  held control; equals CTRL_BUBBLE when out_valid=0
- out_data  out  DATA_W  held data; holds its last value when out_valid=0
- occupancy  out  2  number of held beats (0..2; max 1 when SKID=0)

## Operation
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main entry (drives out_*), plus a skid entry when SKID=1.
- State machine (SKID=1):
  - EMPTY: in_fire -> ONE, main <= in.
  - ONE: in_fire & !out_fire -> TWO, skid <= in. !in_fire & out_fire -> EMPTY. in_fire & out_fire -> ONE, main <= in. Otherwise hold.
  - TWO: in_ready=0. out_fire -> ONE, main <= skid. Otherwise hold.
- SKID=0: states EMPTY/ONE only. in_ready = !out_valid | out_ready. ONE with in_fire & out_fire -> ONE, main <= in.
- in_ready (SKID=1) is registered: 1 in EMPTY and ONE, 0 in TWO. The next-cycle value derives from the next state.
- out_valid = (state != EMPTY). occupancy = 0/1/2 for EMPTY/ONE/TWO.
- flush has top priority. Next state is EMPTY regardless of in_fire/out_fire. A beat accepted in the flush cycle is dropped. An out_fire in the flush cycle still completes, because downstream has already sampled it. Data registers are not cleared by flush.
- No beat is duplicated, reordered, or lost except by flush.

## Timing
- Reset (rst_n=0, asynchronous):
  - state EMPTY, out_valid=0, out_ctrl=CTRL_BUBBLE, out_data=0, skid=0, occupancy=0.
  - in_ready=0 while reset is asserted; in_ready=1 from the first rising edge after release.
- Latency: 1 cycle, from in_fire at edge N to out_valid at edge N+1 (from EMPTY).
- Throughput: 1 beat/cycle sustained when out_ready=1.
- SKID=1: no combinational path from out_ready to in_ready. After out_ready drops, up to one extra beat is absorbed.
- SKID=0: combinational out_ready -> in_ready path is permitted.
- Control/data inputs are sampled only on in_fire. Outputs change only on rising clk.

## Test plan
- Reset mid-stream: hold state TWO, assert rst_n=0 asynchronously -> out_valid=0 and out_ctrl=0 immediately, occupancy=0; after release, in_ready=1 on the next edge.
- Streaming (SKID=1): 8 beats, in_data=i, out_ready=1 -> out_data=0..7 on consecutive cycles starting 1 cycle after the first in_fire; in_ready stays 1.
- Backpressure: stream beats A, B, C; drop out_ready after A is presented -> B goes to skid, occupancy=2, in_ready=0, C is held upstream. Raise out_ready -> output order A, B, C, no loss.
- Flush with simultaneous events: state TWO, flush=1 with out_ready=1 and in_valid=1 -> A completes, skid beat and incoming beat are discarded. Next cycle: occupancy=0, out_valid=0, out_ctrl=CTRL_BUBBLE.
- Bubble control: ctrl=12'hFFF beat consumed, no new input -> out_ctrl returns to CTRL_BUBBLE while out_data keeps its last value.
- SKID=0 variant: out_ready=0 while ONE -> in_ready=0 in the same cycle. Simultaneous in_fire & out_fire -> replacement with no bubble.
